// File: rtl/imem_loader_if.sv
// Byte-stream in / imem write port out bundle for the instruction-memory loader.
// Master drives the control pulses and the byte stream; slave (the loader) drives
// the handshake ready, the imem write port and the status flags.
interface imem_loader_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, abort, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, abort, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into imem: 16-bit LE word count, then LE words.
// Latency: imem write pulses 1 cycle after the 4th byte of a word; 1 byte/cycle sustained.
// Backpressure: rx_ready is high only while loading (LEN_LO/LEN_HI/DATA); bytes wait otherwise.
// Ports: clk, rst (async, active-high), bus (imem_loader_if.slave): start/abort pulses,
//        rx_valid/rx_data/rx_ready byte stream, we/waddr/wdata imem write, cpu_hold/done/err.
module imem_loader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t              r_state;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [ADDR_W:0]     r_word_idx;   // one extra bit so a DEPTH-word image can be counted
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_buf;        // bytes b2,b1,b0 of the word being assembled
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_err;

    logic                w_rx_ready;
    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_last;

    assign w_rx_ready = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
    assign w_accept   = bus.rx_valid && w_rx_ready;
    assign w_len      = {bus.rx_data, r_len_lo};
    assign w_last     = (16'(r_word_idx) == (r_len - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_buf      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Abort takes priority over everything, including a byte offered in the
            // same cycle: that byte is dropped and no further write is issued.
            if (bus.abort) begin
                r_state    <= IDLE;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_cpu_hold <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE, ERR: begin
                        if (bus.start) begin
                            r_state    <= LEN_LO;
                            r_done     <= 1'b0;
                            r_err      <= 1'b0;
                            r_cpu_hold <= 1'b1;
                            r_word_idx <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                    LEN_LO: begin
                        if (w_accept) begin
                            r_len_lo <= bus.rx_data;
                            r_state  <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (w_accept) begin
                            r_len <= w_len;
                            if ((w_len == 16'd0) || (w_len > 16'(DEPTH))) begin
                                r_state    <= ERR;
                                r_err      <= 1'b1;
                                r_cpu_hold <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (w_accept) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                r_we       <= 1'b1;
                                r_waddr    <= r_word_idx[ADDR_W-1:0];
                                r_wdata    <= {bus.rx_data, r_buf};
                                r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
                                // Leave hold on the same edge that registers the last
                                // write, so done and the final we appear together.
                                if (w_last) begin
                                    r_state    <= DONE;
                                    r_done     <= 1'b1;
                                    r_cpu_hold <= 1'b0;
                                end
                            end else begin
                                r_buf <= {bus.rx_data, r_buf[23:8]};
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, logs imem writes, checks results.
module tb_imem_loader;
    logic clk;
    logic rst;

    imem_loader_if #(.WIDTH(32), .ADDR_W(8)) bus ();

    imem_loader #(.WIDTH(32), .DEPTH(256), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int gap_max = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    // Log every write pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_addr.push_back(bus.waddr);
            wr_data.push_back(bus.wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded wait).
    task automatic send(input logic [7:0] b);
        int cnt;
        if (gap_max > 0) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cnt = 0;
        while (bus.rx_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        if (cnt >= 50) check("rx_accept_timeout", {31'b0, bus.rx_ready}, 32'd1);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        int bad;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
        check("rst_we",       {31'b0, bus.we},       32'd0);
        check("rst_cpu_hold", {31'b0, bus.cpu_hold}, 32'd0);
        check("rst_done",     {31'b0, bus.done},     32'd0);
        check("rst_err",      {31'b0, bus.err},      32'd0);
        check("rst_waddr",    {24'b0, bus.waddr},    32'd0);
        check("rst_wdata",    bus.wdata,             32'd0);
        rst = 1'b0;
        tick();

        // Test 1: two-word image, back-to-back bytes
        pulse_start();
        check("t1_hold_loading", {31'b0, bus.cpu_hold}, 32'd1);
        check("t1_ready_loading", {31'b0, bus.rx_ready}, 32'd1);
        send(8'h02); send(8'h00);
        send_word(32'h0000_0013);
        check("t1_we_after_word0", {31'b0, bus.we}, 32'd1);
        check("t1_hold_mid", {31'b0, bus.cpu_hold}, 32'd1);
        send_word(32'h0010_0093);
        check("t1_last_we", {31'b0, bus.we}, 32'd1);
        check("t1_done_with_we", {31'b0, bus.done}, 32'd1);
        check("t1_hold_released", {31'b0, bus.cpu_hold}, 32'd0);
        repeat (3) tick();
        check("t1_we_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_addr0", {24'b0, wr_addr[0]}, 32'd0);
            check("t1_data0", wr_data[0], 32'h0000_0013);
            check("t1_addr1", {24'b0, wr_addr[1]}, 32'd1);
            check("t1_data1", wr_data[1], 32'h0010_0093);
        end
        check("t1_waddr_held", {24'b0, bus.waddr}, 32'd1);
        check("t1_wdata_held", bus.wdata, 32'h0010_0093);
        clear_log();

        // Test 2: same image with random gaps in rx_valid
        pulse_start();
        check("t2_done_cleared", {31'b0, bus.done}, 32'd0);
        gap_max = 3;
        send(8'h02); send(8'h00);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        gap_max = 0;
        repeat (3) tick();
        check("t2_done", {31'b0, bus.done}, 32'd1);
        check("t2_we_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t2_data0", wr_data[0], 32'h0000_0013);
            check("t2_data1", wr_data[1], 32'h0010_0093);
            check("t2_addr1", {24'b0, wr_addr[1]}, 32'd1);
        end
        clear_log();

        // Test 3: zero length and oversize length headers
        pulse_start();
        send(8'h00); send(8'h00);
        check("t3_err_zero", {31'b0, bus.err}, 32'd1);
        check("t3_ready_err", {31'b0, bus.rx_ready}, 32'd0);
        check("t3_hold_err", {31'b0, bus.cpu_hold}, 32'd0);
        check("t3_done_err", {31'b0, bus.done}, 32'd0);
        pulse_start();
        check("t3_err_cleared", {31'b0, bus.err}, 32'd0);
        send(8'h01); send(8'h01);
        check("t3_err_257", {31'b0, bus.err}, 32'd1);
        repeat (3) tick();
        check("t3_no_we", 32'(wr_addr.size()), 32'd0);
        clear_log();

        // Test 4: full 256-word image, word i = i*4
        pulse_start();
        send(8'h00); send(8'h01);
        for (int i = 0; i < 256; i++) send_word(32'(i * 4));
        check("t4_done", {31'b0, bus.done}, 32'd1);
        check("t4_last_waddr", {24'b0, bus.waddr}, 32'd255);
        check("t4_last_wdata", bus.wdata, 32'h0000_03FC);
        repeat (2) tick();
        check("t4_we_count", 32'(wr_addr.size()), 32'd256);
        bad = 0;
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < 256; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== 32'(i * 4)) bad++;
        end
        check("t4_words", 32'(bad), 32'd0);
        clear_log();

        // Test 5: abort after 6 data bytes of a 2-word load
        pulse_start();
        send(8'h02); send(8'h00);
        send_word(32'hAABB_CCDD);
        send(8'h11); send(8'h22);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_ready_idle", {31'b0, bus.rx_ready}, 32'd0);
        check("t5_hold_idle", {31'b0, bus.cpu_hold}, 32'd0);
        check("t5_done_idle", {31'b0, bus.done}, 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        repeat (6) tick();
        bus.rx_valid = 1'b0;
        check("t5_ready_still_idle", {31'b0, bus.rx_ready}, 32'd0);
        check("t5_we_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t5_addr0", {24'b0, wr_addr[0]}, 32'd0);
            check("t5_data0", wr_data[0], 32'hAABB_CCDD);
        end
        clear_log();

        // Test 6: reset mid-word, then fresh single-word load
        pulse_start();
        send(8'h02); send(8'h00);
        send(8'hEE); send(8'hFF);
        rst = 1'b1;
        #2;
        check("t6_rst_hold", {31'b0, bus.cpu_hold}, 32'd0);
        check("t6_rst_ready", {31'b0, bus.rx_ready}, 32'd0);
        check("t6_rst_waddr", {24'b0, bus.waddr}, 32'd0);
        check("t6_rst_wdata", bus.wdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        check("t6_done", {31'b0, bus.done}, 32'd1);
        repeat (2) tick();
        check("t6_we_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t6_addr0", {24'b0, wr_addr[0]}, 32'd0);
            check("t6_data0", wr_data[0], 32'h1234_5678);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
